instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, address width.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port pc_address, input, XLEN, current address from program_counter.
REQ-006 SHALL have port pc_enable_n, output, 1, low advances program_counter by 4 at next edge.
REQ-007 SHALL have port pc_load, output, 1, loads pc_new_address into program_counter (priority over advance).
REQ-008 SHALL have port pc_new_address, output, XLEN, redirect target.
REQ-009 SHALL have ports redirect_valid (input, 1) and redirect_address (input, XLEN): branch/jump redirect from execute.
REQ-010 SHALL have ports imem_req_valid (output, 1), imem_req_ready (input, 1), imem_req_address (output, XLEN): memory request handshake.
REQ-011 SHALL have ports imem_resp_valid (input, 1), imem_resp_data (input, 32): response, no backpressure.
REQ-012 SHALL have ports inst_valid (output, 1), inst_ready (input, 1), inst_data (output, 32), inst_address (output, XLEN): to decode.
REQ-013 SHALL have port fetch_fault, output, 1, sticky misaligned-PC flag.

Function
REQ-014 SHALL implement FSM states REQUEST, WAIT, DRAIN, FAULT.
REQ-015 REQUEST: imem_req_valid=1, imem_req_address=pc_address, only when pc_address[1:0]==0 and buffer occupancy+in-flight < BUF_DEPTH.
REQ-016 On req handshake (valid&&ready): pc_enable_n=0 that cycle, capture pc_address as in-flight tag, go WAIT; otherwise pc_enable_n=1.
REQ-017 imem_req_valid SHALL stay high with stable address until ready, unless a redirect occurs.
REQ-018 WAIT: on imem_resp_valid, push {tag, imem_resp_data} into buffer, return to REQUEST; at most one outstanding request.
REQ-019 Response arriving same cycle as decode pop from full buffer SHALL be accepted (pop-then-push).
REQ-020 inst_valid = buffer non-empty; pop on inst_valid&&inst_ready; data/address SHALL hold stable while valid&&!ready.
REQ-021 redirect_valid SHALL, same cycle: pc_load=1, pc_new_address=redirect_address, imem_req_valid=0, flush buffer (inst_valid=0 next cycle).
REQ-022 Redirect while WAIT (or coinciding with req handshake) SHALL go DRAIN; DRAIN discards exactly one response then REQUEST.
REQ-023 Redirect coinciding with imem_resp_valid in WAIT SHALL drop that response and go REQUEST directly.
REQ-024 Redirect in FAULT SHALL clear fetch_fault and go REQUEST.
REQ-025 pc_address[1:0]!=0 in REQUEST SHALL go FAULT: fetch_fault=1, no requests, pc_enable_n=1, buffered instructions still drain.
REQ-026 Buffer pointers SHALL wrap modulo BUF_DEPTH; count width clog2(BUF_DEPTH)+1.

Reset
REQ-027 reset SHALL, at next edge, force REQUEST, empty buffer, clear tag, fetch_fault=0; overrides redirect and responses.
REQ-028 While reset asserted: imem_req_valid=0, inst_valid=0, pc_enable_n=1, pc_load=0, pc_new_address=0.
REQ-029 Response for a request in flight at reset SHALL be discarded (enter DRAIN-equivalent after reset if a request was outstanding).

Structure
REQ-030 fetch_pkg SHALL hold XLEN, ILEN=32, FSM state enum, and fetch entry struct {address, instruction}.
REQ-031 Buffer SHALL be sub-module fetch_buffer (parameterized sync FIFO: push, pop, full, empty, count, flush).

Verification
REQ-032 Reset then memory ready always, 1-cycle response, decode ready: PC 0,4,8,C delivered with matching data, one per 2 cycles.
REQ-033 Decode ready low 10 cycles: exactly BUF_DEPTH entries buffered, no further requests, pc_enable_n=1; release drains in order.
REQ-034 Redirect to 0x100 while WAIT: response for old PC dropped, next delivered inst_address=0x100, pc_load high exactly one cycle.
REQ-035 Redirect to 0x102: fetch_fault=1, no imem_req_valid; redirect to 0x200 clears fault and fetches 0x200.
REQ-036 imem_req_ready low 5 cycles: address stable, pc_enable_n=1 throughout; reset mid-WAIT: late response discarded, fetch restarts at pc_address.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice: widths, fetch FSM states,
// buffered entry layout and a small alignment helper.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {
    REQUEST = 2'd0,
    WAIT    = 2'd1,
    DRAIN   = 2'd2,
    FAULT   = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [ILEN-1:0] instruction;
  } fetch_entry_t;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: instruction memory request/response plus the
// decode-facing instruction stream. master = fetch unit, slave = environment.
interface instruction_fetch_if #(
  parameter int XLEN = 32
);
  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_address;
  logic            imem_resp_valid;
  logic [31:0]     imem_resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_address;

  modport master (
    output imem_req_valid, imem_req_address, inst_valid, inst_data, inst_address,
    input  imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_address, inst_valid, inst_data, inst_address,
    output imem_req_ready, imem_resp_valid, imem_resp_data, inst_ready
  );
endinterface

// File: rtl/fetch_buffer.sv
// Synchronous FIFO holding fetched {address, instruction} entries.
// A push into a full buffer is accepted when a pop happens in the same cycle.
module fetch_buffer #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_push, do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  // Pointers are exactly AW bits wide, so increments wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Single-outstanding instruction fetch: requests at the program counter,
// buffers responses for decode, handles redirects and misaligned-PC faults.
module instruction_fetch #(
  parameter int XLEN      = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [XLEN-1:0]      pc_address,
  output logic                 pc_enable_n,
  output logic                 pc_load,
  output logic [XLEN-1:0]      pc_new_address,
  input  logic                 redirect_valid,
  input  logic [XLEN-1:0]      redirect_address,
  output logic                 fetch_fault,
  instruction_fetch_if.master  bus
);
  import fetch_pkg::*;

  localparam int CW = $clog2(BUF_DEPTH) + 1;
  localparam int EW = XLEN + ILEN;

  fetch_state_t    state;
  logic [XLEN-1:0] tag;
  logic            fault_q;

  logic [CW-1:0]   count;
  logic            buf_full, buf_empty;
  logic [EW-1:0]   head;

  logic aligned, in_flight, has_room, req_valid, req_fire;
  logic push, pop;

  assign aligned   = is_aligned(pc_address[1:0]);
  assign in_flight = (state == WAIT) || (state == DRAIN);
  assign has_room  = !buf_full && ((count + CW'(in_flight)) < CW'(BUF_DEPTH));
  assign req_valid = !reset && !redirect_valid && (state == REQUEST) && aligned && has_room;
  assign req_fire  = req_valid && bus.imem_req_ready;

  // A response landing together with a redirect belongs to the old path.
  assign push = (state == WAIT) && bus.imem_resp_valid && !redirect_valid;
  assign pop  = bus.inst_valid && bus.inst_ready;

  assign bus.imem_req_valid   = req_valid;
  assign bus.imem_req_address = pc_address;
  assign bus.inst_valid       = !buf_empty && !reset;
  assign bus.inst_data        = head[ILEN-1:0];
  assign bus.inst_address     = head[EW-1:ILEN];

  assign pc_enable_n    = !req_fire;
  assign pc_load        = redirect_valid && !reset;
  assign pc_new_address = reset ? '0 : redirect_address;
  assign fetch_fault    = fault_q;

  fetch_buffer #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush     (pc_load),
    .push      (push),
    .push_data ({tag, bus.imem_resp_data}),
    .pop       (pop),
    .pop_data  (head),
    .full      (buf_full),
    .empty     (buf_empty),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      // A request still owed a response must have that response swallowed.
      if (in_flight && !bus.imem_resp_valid) state <= DRAIN;
      else                                   state <= REQUEST;
      tag     <= '0;
      fault_q <= 1'b0;
    end else begin
      unique case (state)
        REQUEST: begin
          if (redirect_valid) begin
            state <= REQUEST;
          end else if (!aligned) begin
            state   <= FAULT;
            fault_q <= 1'b1;
          end else if (req_fire) begin
            state <= WAIT;
            tag   <= pc_address;
          end
        end
        WAIT: begin
          if (bus.imem_resp_valid) state <= REQUEST;
          else if (redirect_valid) state <= DRAIN;
        end
        DRAIN: begin
          if (bus.imem_resp_valid) state <= REQUEST;
        end
        FAULT: begin
          if (redirect_valid) begin
            state   <= REQUEST;
            fault_q <= 1'b0;
          end
        end
        default: state <= REQUEST;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch against a transaction-level model:
// a memory with one pending transaction, a program-order instruction queue and a fault flag.
module tb_instruction_fetch;
  import fetch_pkg::*;

  localparam int XL    = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [XL-1:0] pc_address, pc_new_address, redirect_address;
  logic          pc_enable_n, pc_load, redirect_valid, fetch_fault;

  instruction_fetch_if #(.XLEN(XL)) bus ();

  instruction_fetch #(.XLEN(XL), .BUF_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_address       (pc_address),
    .pc_enable_n      (pc_enable_n),
    .pc_load          (pc_load),
    .pc_new_address   (pc_new_address),
    .redirect_valid   (redirect_valid),
    .redirect_address (redirect_address),
    .fetch_fault      (fetch_fault),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0, errors = 0, cyc = 0;

  // stimulus knobs
  int  ready_pct = 100, iready_pct = 100, redir_pct = 0, rst_pm = 0;
  int  lat_min = 1, lat_max = 1;
  bit  force_redir = 0, force_rst = 0;
  logic [31:0] force_addr = '0;

  // model state
  logic [31:0]  pc, pc_nx;
  bit           busy = 0, stale = 0, fault_exp = 0;
  logic [31:0]  out_addr = '0;
  int           out_lat = 0;
  fetch_entry_t q[$];
  logic [31:0]  got_addr[$], got_data[$];
  int           got_cyc[$];
  int           load_cnt = 0, req_cnt = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [31:0] ga(input int i);
    return (i < got_addr.size()) ? got_addr[i] : 32'hDEAD_DEAD;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit rsp, hs, pop, acc, was_busy, req_exp;
    fetch_entry_t ent;
    @(negedge clk);
    cyc++;
    pc         = pc_nx;
    pc_address = pc;
    reset          = force_rst || ($urandom_range(999) < rst_pm);
    redirect_valid = force_redir || ($urandom_range(99) < redir_pct);
    if (force_redir)                redirect_address = force_addr;
    else if ($urandom_range(9) == 0) redirect_address = {22'b0, 8'($urandom), 2'($urandom_range(3, 1))};
    else                            redirect_address = {22'b0, 8'($urandom), 2'b00};
    bus.imem_req_ready  = ($urandom_range(99) < ready_pct);
    rsp                 = busy && (out_lat == 0);
    bus.imem_resp_valid = rsp;
    bus.imem_resp_data  = rsp ? mem(out_addr) : $urandom;
    bus.inst_ready      = ($urandom_range(99) < iready_pct);
    #1;

    // compare against the model
    req_exp = !reset && !redirect_valid && !busy && !fault_exp &&
              (pc[1:0] == 2'b00) && (q.size() < DEPTH);
    chk("imem_req_valid", bus.imem_req_valid, req_exp);
    if (req_exp) chk("imem_req_address", bus.imem_req_address, pc);
    chk("pc_enable_n", pc_enable_n, !(req_exp && bus.imem_req_ready));
    chk("pc_load", pc_load, !reset && redirect_valid);
    if (reset)               chk("pc_new_address_rst", pc_new_address, 0);
    else if (redirect_valid) chk("pc_new_address", pc_new_address, redirect_address);
    chk("fetch_fault", fetch_fault, fault_exp);
    chk("inst_valid", bus.inst_valid, !reset && (q.size() != 0));
    if (!reset && q.size() != 0) begin
      chk("inst_address", bus.inst_address, q[0].address);
      chk("inst_data", bus.inst_data, q[0].instruction);
    end

    // advance the model across the coming edge
    hs       = req_exp && bus.imem_req_ready;
    pop      = !reset && (q.size() != 0) && bus.inst_ready;
    was_busy = busy;
    acc      = 0;
    ent      = '{address: out_addr, instruction: mem(out_addr)};
    if (rsp) begin
      busy = 0;
      acc  = !stale && !reset && !redirect_valid;
    end else if (busy) begin
      out_lat--;
      if (reset || redirect_valid) stale = 1;
    end
    if (reset || redirect_valid) begin
      q.delete();
    end else begin
      if (pop) begin
        got_addr.push_back(bus.inst_address);
        got_data.push_back(bus.inst_data);
        got_cyc.push_back(cyc);
        void'(q.pop_front());
      end
      if (acc) q.push_back(ent);
    end
    if (hs) begin
      busy     = 1;
      stale    = 0;
      out_addr = pc;
      out_lat  = int'($urandom_range(lat_max, lat_min)) - 1;
      req_cnt++;
    end
    if (reset || redirect_valid)                fault_exp = 0;
    else if (!was_busy && pc[1:0] != 2'b00)     fault_exp = 1;
    if (pc_load) load_cnt++;
    if (pc_load)           pc_nx = pc_new_address;
    else if (!pc_enable_n) pc_nx = pc + 32'd4;
    else                   pc_nx = pc;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wait_busy(input string name);
    int k = 0;
    while (!busy && k < 40) begin step(); k++; end
    chk(name, busy, 1);
  endtask

  task automatic wait_got(input int n0, input string name);
    int k = 0;
    while (got_addr.size() <= n0 && k < 60) begin step(); k++; end
    chk(name, got_addr.size() > n0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, lc0, rc0;
    logic [31:0] last, a0, rpc;
    pc_nx = '0; pc = '0; pc_address = '0;
    reset = 1'b1; redirect_valid = 1'b0; redirect_address = '0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0;
    bus.imem_resp_data = '0; bus.inst_ready = 1'b0;

    force_rst = 1; run(3); force_rst = 0;
    chk("reset_inst_valid", bus.inst_valid, 0);
    chk("reset_pc_enable_n", pc_enable_n, 1);

    // sequential fetch from 0, one delivery per two cycles
    run(10);
    chk("seq_count", got_addr.size() >= 4, 1);
    chk("seq_a0", ga(0), 32'h0);
    chk("seq_a1", ga(1), 32'h4);
    chk("seq_a2", ga(2), 32'h8);
    chk("seq_a3", ga(3), 32'hC);
    if (got_data.size() >= 4) chk("seq_d3", got_data[3], 32'hC0DE_000C);
    if (got_cyc.size() >= 4) begin
      chk("seq_rate01", got_cyc[1] - got_cyc[0], 2);
      chk("seq_rate23", got_cyc[3] - got_cyc[2], 2);
    end

    // decode stall fills the buffer and stops requests
    iready_pct = 0;
    run(10);
    rc0 = req_cnt;
    run(3);
    chk("stall_no_req", req_cnt - rc0, 0);
    chk("stall_req_valid", bus.imem_req_valid, 0);
    chk("stall_pc_enable_n", pc_enable_n, 1);
    chk("stall_occupancy", q.size(), DEPTH);
    n0 = got_addr.size();
    last = ga(n0 - 1);
    iready_pct = 100;
    run(8);
    chk("drain_order0", ga(n0), last + 32'd4);
    chk("drain_order1", ga(n0 + 1), last + 32'd8);

    // redirect while waiting on memory
    lat_min = 3; lat_max = 3;
    wait_busy("redir_wait_timeout");
    lc0 = load_cnt;
    force_redir = 1; force_addr = 32'h100;
    step();
    force_redir = 0;
    n0 = got_addr.size();
    wait_got(n0, "redir_deliver_timeout");
    chk("redir_target", ga(n0), 32'h100);
    chk("redir_pc_load_once", load_cnt - lc0, 1);

    // misaligned redirect faults, aligned redirect recovers
    lat_min = 1; lat_max = 1;
    rc0 = req_cnt;
    force_redir = 1; force_addr = 32'h102;
    step();
    force_redir = 0;
    run(6);
    chk("fault_set", fetch_fault, 1);
    chk("fault_no_req", req_cnt - rc0, 0);
    force_redir = 1; force_addr = 32'h200;
    step();
    force_redir = 0;
    n0 = got_addr.size();
    wait_got(n0, "fault_recover_timeout");
    chk("fault_recover_addr", ga(n0), 32'h200);
    chk("fault_cleared", fetch_fault, 0);

    // memory not ready: request held stable
    ready_pct = 0;
    run(3);
    a0 = bus.imem_req_address;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_valid", bus.imem_req_valid, 1);
      chk("hold_addr", bus.imem_req_address, a0);
      chk("hold_pc_enable_n", pc_enable_n, 1);
    end

    // reset while a response is outstanding
    ready_pct = 100; lat_min = 4; lat_max = 4;
    wait_busy("rst_wait_timeout");
    rpc = out_addr + 32'd4;
    force_rst = 1; run(2); force_rst = 0;
    n0 = got_addr.size();
    wait_got(n0, "rst_restart_timeout");
    chk("rst_restart_addr", ga(n0), rpc);

    // random traffic
    ready_pct = 70; iready_pct = 60; redir_pct = 4; rst_pm = 5;
    lat_min = 1; lat_max = 3;
    run(3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
